// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types and constants.
// Used by ps2_frame_rx and by the downstream scan-code decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } Ps2RxState;

    localparam int         PS2_DATA_BITS = 8;
    localparam logic [7:0] PS2_BREAK     = 8'hF0;
    localparam logic [7:0] PS2_EXT       = 8'hE0;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus glitch filter for one PS/2 pin.
// Ports: clock, reset_n (sync, active low), raw_i (async pin),
//        filt_o (filtered level), fall_o (1-cycle falling-edge strobe).
module ps2_line_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw_i,
    output logic filt_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic          s1_q;
    logic          s2_q;
    logic          filt_q;
    logic          filt_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count consecutive samples that disagree with the filtered level;
    // any agreeing sample restarts the count.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (s2_q != filt_q) begin
            if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
                filt_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            filt_q <= 1'b1;
            prev_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            s1_q   <= raw_i;
            s2_q   <= s1_q;
            filt_q <= filt_d;
            prev_q <= filt_q;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;
    assign fall_o = prev_q & ~filt_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver (start, 8 data LSB-first, odd parity, stop).
// Ports: clock, reset_n (sync, active low), ps2_clock/ps2_data (raw pins),
//        ps2_code (last good byte), ps2_code_new (strobe), frame_err (strobe).
// Build option: define PS2_PARITY_CHECK_EN to drop frames with bad parity.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic [7:0] ps2_code,
    output logic       ps2_code_new,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic      clk_fall;
    logic      clk_filt_unused;
    logic      data_filt;
    logic      data_fall_unused;

    Ps2RxState state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    code_q, code_d;
    logic          new_q, new_d;
    logic          err_q, err_d;
    logic          parity_ok;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filt (
        .clock   (clock),
        .reset_n (reset_n),
        .raw_i   (ps2_clock),
        .filt_o  (clk_filt_unused),
        .fall_o  (clk_fall)
    );

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filt (
        .clock   (clock),
        .reset_n (reset_n),
        .raw_i   (ps2_data),
        .filt_o  (data_filt),
        .fall_o  (data_fall_unused)
    );

`ifdef PS2_PARITY_CHECK_EN
    logic par_q, par_d;
    assign parity_ok = ^{shift_q, par_q};
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tmo_d   = '0;
        code_d  = code_q;
        new_d   = 1'b0;
        err_d   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_d   = par_q;
`endif
        if (clk_fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_filt) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d = {data_filt, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'(PS2_DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d = data_filt;
`endif
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_filt && parity_ok) begin
                        code_d = shift_q;
                        new_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // Fires as the counter would step onto TIMEOUT_CYCLES-1.
            if (tmo_q == TW'(TIMEOUT_CYCLES - 2)) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            tmo_q   <= '0;
            code_q  <= 8'h00;
            new_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tmo_q   <= tmo_d;
            code_q  <= code_d;
            new_q   <= new_d;
            err_q   <= err_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q   <= par_d;
`endif
        end
    end

    assign ps2_code     = code_q;
    assign ps2_code_new = new_q;
    assign frame_err    = err_q;

endmodule
